// File: rtl/mm_feature_buffer_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mm_feature_buffer_resp
// Description : One feature-buffer bank. It serves pipelined mm reads and mm
//               writes, and has a zero-clear sweep. Define MM_BUF_WR_BYPASS_EN
//               for write-first behaviour on a same-address read/write.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_feature_buffer_resp #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 2
) (
    input  logic              kernal_clk,
    input  logic              kernal_rst,
    input  logic              rd_avalid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              rw_conflict,
    output logic              err_drop
);

    localparam int        DEPTH   = 1 << ADDR_W;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              conflict_q, err_q;
    logic              rd1_valid_q;
    logic [DATA_W-1:0] rd1_data_q;

    logic              w_blocked;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_conflict;
    logic [DATA_W-1:0] w_rd_word;

    // Requests that arrive during the sweep or on its start cycle are dropped.
    assign w_blocked  = (state_q == S_CLEAR) | clr_start;
    assign w_rd_acc   = rd_avalid & ~w_blocked;
    assign w_wr_acc   = wr_valid & ~w_blocked;
    assign w_conflict = w_rd_acc & w_wr_acc & (rd_addr == wr_addr);
    assign clr_busy   = (state_q == S_CLEAR);

`ifdef MM_BUF_WR_BYPASS_EN
    assign w_rd_word = w_conflict ? wr_data : mem_q[rd_addr];
`else
    assign w_rd_word = mem_q[rd_addr];
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge kernal_clk) begin
        if (kernal_rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            conflict_q <= conflict_q | w_conflict;
            err_q      <= err_q | (w_blocked & (rd_avalid | wr_valid));
        end
    end

    assign rw_conflict = conflict_q;
    assign err_drop    = err_q;

    // The array is never reset; a reset edge suppresses any write on that edge.
    always_ff @(posedge kernal_clk) begin
        if (!kernal_rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[ptr_q] <= '0;
            end else if (w_wr_acc) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge kernal_clk) begin
        if (kernal_rst) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= w_rd_acc;
            if (w_rd_acc) begin
                rd1_data_q <= w_rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              rd2_valid_q;
            logic [DATA_W-1:0] rd2_data_q;

            always_ff @(posedge kernal_clk) begin
                if (kernal_rst) begin
                    rd2_valid_q <= 1'b0;
                    rd2_data_q  <= '0;
                end else begin
                    rd2_valid_q <= rd1_valid_q;
                    if (rd1_valid_q) begin
                        rd2_data_q <= rd1_data_q;
                    end
                end
            end

            assign rd_valid = rd2_valid_q;
            assign rd_data  = rd2_data_q;
        end else if (RD_LAT == 1) begin : g_lat1
            assign rd_valid = rd1_valid_q;
            assign rd_data  = rd1_data_q;
        end else begin : g_bad_lat
            $error("mm_feature_buffer_resp: RD_LAT must be 1 or 2");
            assign rd_valid = 1'b0;
            assign rd_data  = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mm_feature_buffer_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mm_feature_buffer_resp
// Description : Directed bench for mm_feature_buffer_resp. It uses a cycle-level
//               reference model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_feature_buffer_resp;

    localparam int DW    = 512;
    localparam int AW    = 11;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef MM_BUF_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_avalid;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_start;
    logic          clr_busy;
    logic          rw_conflict;
    logic          err_drop;

    mm_feature_buffer_resp #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) u_dut (
        .kernal_clk  (clk),
        .kernal_rst  (rst),
        .rd_avalid   (rd_avalid),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .rw_conflict (rw_conflict),
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    // Reference model: a flat array, a countdown for the sweep, and a queue of reads.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0] mmem [DEPTH];
    rd_t           pend [$];
    rd_t           e;
    int            cyc     = 0;
    int            m_busy  = 0;
    bit            m_conf  = 0;
    bit            m_err   = 0;
    bit            started = 0;
    bit            blocked;
    bit            exp_v;
    logic [DW-1:0] m_data;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            m_busy  = 0;
            m_conf  = 0;
            m_err   = 0;
            m_data  = '0;
            started = 1;
        end else begin
            blocked = (m_busy > 0) || clr_start;
            if (blocked && (rd_avalid || wr_valid)) m_err = 1;
            if (m_busy > 0) begin
                mmem[DEPTH - m_busy] = '0;
                m_busy--;
            end else if (clr_start) begin
                m_busy = DEPTH;
            end
            if (!blocked) begin
                if (rd_avalid) begin
                    if (wr_valid && wr_addr == rd_addr) m_conf = 1;
                    e.d   = (BYPASS && wr_valid && wr_addr == rd_addr) ? wr_data : mmem[rd_addr];
                    e.due = cyc + LAT - 1;
                    pend.push_back(e);
                end
                if (wr_valid) mmem[wr_addr] = wr_data;
            end
        end
    end

    logic [DW-1:0] obs [$];
    int            obs_cyc [$];

    always @(negedge clk) begin
        if (started) begin
            exp_v = (pend.size() > 0) && (pend[0].due == cyc);
            if (exp_v) begin
                m_data = pend[0].d;
                void'(pend.pop_front());
            end
            chk("rd_valid", DW'(rd_valid), DW'(exp_v));
            chk("rd_data", rd_data, m_data);
            chk("clr_busy", DW'(clr_busy), DW'(m_busy > 0));
            chk("rw_conflict", DW'(rw_conflict), DW'(m_conf));
            chk("err_drop", DW'(err_drop), DW'(m_err));
            if (rd_valid === 1'b1) begin
                obs.push_back(rd_data);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_avalid = 1'b1;
        rd_addr   = a;
        tick();
        rd_avalid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_clear_done(input string name, output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (clr_busy === 1'b1) begin
                n++;
                tick();
            end else begin
                done = 1;
            end
        end
        if (!done) chk(name, DW'(1), DW'(0));
    endtask

    int            req_cyc;
    int            nbusy;
    logic [DW-1:0] t3_exp;

    initial begin
        rst       = 1'b1;
        rd_avalid = 1'b0;
        rd_addr   = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_start = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_rd_data", rd_data, '0);
        chk("reset_flags", DW'({rd_valid, clr_busy, rw_conflict, err_drop}), '0);

        // 1: write then read one word
        obs.delete(); obs_cyc.delete();
        do_write(5, {64{8'hAA}});
        req_cyc = cyc;
        do_read(5);
        tick(LAT + 2);
        chk("t1_count", DW'(obs.size()), DW'(1));
        chk("t1_data", obs[0], {64{8'hAA}});
        chk("t1_latency", DW'(obs_cyc[0] - req_cyc), DW'(LAT));

        // 2: back-to-back reads
        for (int i = 0; i < 16; i++) do_write(AW'(i), DW'(i));
        obs.delete(); obs_cyc.delete();
        rd_avalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = AW'(i);
            tick();
        end
        rd_avalid = 1'b0;
        tick(LAT + 2);
        chk("t2_count", DW'(obs.size()), DW'(16));
        chk("t2_first", obs[0], DW'(0));
        chk("t2_mid", obs[9], DW'(9));
        chk("t2_last", obs[15], DW'(15));
        chk("t2_span", DW'(obs_cyc[15] - obs_cyc[0]), DW'(15));

        // 3: same-cycle read and write to one address
        do_write(7, DW'(32'h11));
        obs.delete(); obs_cyc.delete();
        rd_avalid = 1'b1; rd_addr = 7;
        wr_valid  = 1'b1; wr_addr = 7; wr_data = DW'(32'h22);
        tick();
        rd_avalid = 1'b0; wr_valid = 1'b0;
        tick(LAT + 2);
        t3_exp = BYPASS ? DW'(32'h22) : DW'(32'h11);
        chk("t3_data", obs[0], t3_exp);
        chk("t3_conflict", DW'(rw_conflict), DW'(1));

        // 4: fill the bank, sweep it, then spot-check
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), {16{32'(i + 1)}});
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_clear_done("t4_timeout", nbusy);
        chk("t4_busy_len", DW'(nbusy), DW'(DEPTH));
        obs.delete(); obs_cyc.delete();
        do_read(0);
        do_read(1024);
        do_read(2047);
        tick(LAT + 2);
        chk("t4_count", DW'(obs.size()), DW'(3));
        chk("t4_d0", obs[0], '0);
        chk("t4_d1024", obs[1], '0);
        chk("t4_d2047", obs[2], '0);

        // 5: requests during the sweep are dropped
        pulse_rst();
        do_write(3, DW'(32'h33));
        obs.delete(); obs_cyc.delete();
        clr_start = 1'b1; rd_avalid = 1'b1; rd_addr = 3;
        tick();
        clr_start = 1'b0; rd_avalid = 1'b0;
        tick(5);
        rd_avalid = 1'b1; rd_addr = 3;
        wr_valid  = 1'b1; wr_addr = 3; wr_data = DW'(32'h55);
        tick();
        rd_avalid = 1'b0; wr_valid = 1'b0;
        wait_clear_done("t5_timeout", nbusy);
        tick(LAT + 2);
        chk("t5_no_valid", DW'(obs.size()), DW'(0));
        chk("t5_err", DW'(err_drop), DW'(1));
        do_read(3);
        tick(LAT + 2);
        chk("t5_not_stored", obs[0], '0);

        // 6: reset kills an in-flight read and an active sweep
        pulse_rst();
        do_write(9, DW'(32'h99));
        obs.delete(); obs_cyc.delete();
        do_read(9);
        pulse_rst();
        tick(LAT + 2);
        chk("t6_no_valid", DW'(obs.size()), DW'(0));
        clr_start = 1'b1; rd_avalid = 1'b1; rd_addr = 9;
        tick();
        clr_start = 1'b0; rd_avalid = 1'b0;
        tick(100);
        chk("t6_busy_mid", DW'(clr_busy), DW'(1));
        pulse_rst();
        tick(2);
        chk("t6_busy", DW'(clr_busy), DW'(0));
        chk("t6_flags", DW'({rw_conflict, err_drop}), DW'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
